uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 138 +++++++++++++
 tb/tb_uart_tx_cfg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter with a small TX FIFO.
//
// Words written through tx_data/tx_en are queued in a DEPTH-entry FIFO.
// The framing FSM pops them one at a time and serialises each word as:
// start bit, DATA_BITS data bits (LSB first), an optional parity bit and
// STOP_BITS stop bits. Every bit lasts BAUD_THRESHOLD clock cycles.
//
// Ports
//   clk      : single clock, all state updates on posedge
//   rst      : synchronous, active-low reset
//   tx_data  : word to transmit (DATA_BITS wide)
//   tx_en    : write strobe, accepted when tx_ready=1
//   tx       : registered serial line, idle high
//   tx_ready : FIFO not full
//   busy     : framing FSM is not idle
//   ctr      : baud counter within the current bit (debug)
//   stage    : bit index within the current frame (debug)
module uart_tx_cfg #(
  parameter int BAUD_THRESHOLD = 4,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int DEPTH          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_en,
  output logic                 tx,
  output logic                 tx_ready,
  output logic                 busy,
  output logic [15:0]          ctr,
  output logic [4:0]           stage
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] CTR_LAST   = 16'(BAUD_THRESHOLD - 1);
  localparam logic [4:0]  DATA_LAST  = 5'(DATA_BITS);
  localparam logic [4:0]  FRAME_LAST = 5'(DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end, push, pop, tx_nxt;

  assign tx_ready = (count != FULL_CNT);
  assign busy     = (state != IDLE);
  assign push     = tx_en && tx_ready;
  assign bit_end  = (ctr == CTR_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // tx_nxt is the line level for the bit currently being timed; it is
  // registered below, so the line trails the FSM by one cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (bit_end && stage == DATA_LAST) state_nxt = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        tx_nxt = par_bit;
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        // Chain straight into the next frame when more data is queued.
        if (bit_end && stage == FRAME_LAST) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control: FIFO pointers, counters and the line register
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ctr    <= '0;
      stage  <= '0;
      tx     <= 1'b1;
    end else begin
      tx <= tx_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == IDLE || bit_end) ctr <= '0;
      else                          ctr <= ctr + 16'd1;
      if (state_nxt == IDLE || state_nxt == START) stage <= '0;
      else if (bit_end)                            stage <= stage + 5'd1;
    end
  end

  // Data: FIFO storage and shift register, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
    if (pop) begin
      shreg   <= mem[rd_ptr];
      par_bit <= (^mem[rd_ptr]) ^ (PARITY == 1);
    end else if (state == DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: four configurations driven by a shared write
// stream and compared every cycle against a frame-level reference model.
module tb_uart_tx_cfg;

  localparam int NC    = 4;
  localparam int B     = 4;
  localparam int DEPTH = 4;
  localparam int CD [NC] = '{8, 8, 8, 7};
  localparam int CP [NC] = '{0, 2, 1, 0};
  localparam int CS [NC] = '{1, 1, 1, 2};
  localparam int EXP_LEN [NC] = '{40, 44, 44, 40};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_en = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_o   [NC];
  logic        rdy_o  [NC];
  logic        busy_o [NC];
  logic [15:0] ctr_o  [NC];
  logic [4:0]  stg_o  [NC];

  always #5 clk = ~clk;

  uart_tx_cfg #(.BAUD_THRESHOLD(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(DEPTH)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_en(tx_en), .tx(tx_o[0]),
    .tx_ready(rdy_o[0]), .busy(busy_o[0]), .ctr(ctr_o[0]), .stage(stg_o[0]));
  uart_tx_cfg #(.BAUD_THRESHOLD(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_en(tx_en), .tx(tx_o[1]),
    .tx_ready(rdy_o[1]), .busy(busy_o[1]), .ctr(ctr_o[1]), .stage(stg_o[1]));
  uart_tx_cfg #(.BAUD_THRESHOLD(B), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(DEPTH)) u2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_en(tx_en), .tx(tx_o[2]),
    .tx_ready(rdy_o[2]), .busy(busy_o[2]), .ctr(ctr_o[2]), .stage(stg_o[2]));
  uart_tx_cfg #(.BAUD_THRESHOLD(B), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DEPTH(DEPTH)) u3 (
    .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_en(tx_en), .tx(tx_o[3]),
    .tx_ready(rdy_o[3]), .busy(busy_o[3]), .ctr(ctr_o[3]), .stage(stg_o[3]));

  int errs;
  int checks;
  int edge_n;
  int busy_cnt [NC];

  // Reference model state: queued words, the frame in flight, and the
  // earliest edge at which the transmitter may take the next word.
  logic [7:0] fq [NC][DEPTH];
  int         fh [NC];
  int         fc [NC];
  int         avail [NC];
  bit         fv [NC];
  int         fst [NC];
  logic [7:0] fw [NC];

  function automatic int flen(int c);
    return (1 + CD[c] + ((CP[c] != 0) ? 1 : 0) + CS[c]) * B;
  endfunction

  function automatic logic fbit(int c, logic [7:0] w, int j);
    if (j == 0) return 1'b0;
    if (j <= CD[c]) return w[j-1];
    if (CP[c] != 0 && j == CD[c] + 1) return (^w) ^ (CP[c] == 1);
    return 1'b1;
  endfunction

  task automatic chk(string tag, int c, logic [15:0] obs, logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errs++;
        $error("FAIL %s dut%0d edge=%0d observed=%0h expected=%0h", tag, c, edge_n, obs, exp_v);
      end
  endtask

  task automatic step();
    logic       en_s, rst_s;
    logic [7:0] d_s;
    en_s  = tx_en;
    rst_s = rst;
    d_s   = tx_data;
    @(posedge clk);
    #1;
    edge_n++;
    for (int c = 0; c < NC; c++) begin
      int   len, t;
      logic e_tx, e_busy;
      bit   acc, pop;
      len  = flen(c);
      e_tx = 1'b1;
      if (!rst_s) begin
        fc[c] = 0; fh[c] = 0; fv[c] = 1'b0; avail[c] = 0;
      end else begin
        t = edge_n - 1 - fst[c];
        if (fv[c] && t >= 0 && t < len) e_tx = fbit(c, fw[c], t / B);
        acc = en_s && (fc[c] < DEPTH);
        pop = (fc[c] > 0) && (edge_n >= avail[c]);
        if (pop) begin
          fw[c]    = fq[c][fh[c]];
          fh[c]    = (fh[c] + 1) % DEPTH;
          fc[c]    = fc[c] - 1;
          fv[c]    = 1'b1;
          fst[c]   = edge_n;
          avail[c] = edge_n + len;
        end
        if (acc) begin
          fq[c][(fh[c] + fc[c]) % DEPTH] = d_s & 8'((1 << CD[c]) - 1);
          fc[c] = fc[c] + 1;
        end
      end
      t      = edge_n - fst[c];
      e_busy = fv[c] && (t < len);
      chk("tx",    c, 16'(tx_o[c]),   16'(e_tx));
      chk("busy",  c, 16'(busy_o[c]), 16'(e_busy));
      chk("ready", c, 16'(rdy_o[c]),  16'(fc[c] != DEPTH));
      chk("ctr",   c, ctr_o[c],       e_busy ? 16'(t % B) : 16'd0);
      chk("stage", c, 16'(stg_o[c]),  e_busy ? 16'(t / B) : 16'd0);
      if (busy_o[c] === 1'b1) busy_cnt[c]++;
    end
  endtask

  task automatic clear_busy();
    for (int c = 0; c < NC; c++) busy_cnt[c] = 0;
  endtask

  initial begin
    int k;
    errs = 0; checks = 0; edge_n = 0;
    for (int c = 0; c < NC; c++) begin
      fh[c] = 0; fc[c] = 0; avail[c] = 0; fv[c] = 1'b0; fst[c] = 0; fw[c] = 8'h00;
      busy_cnt[c] = 0;
    end

    // Reset for two edges with a write pending; the write must be dropped.
    rst = 1'b0; tx_en = 1'b1; tx_data = 8'hA5;
    step(); step();
    tx_en = 1'b0;
    for (int c = 0; c < NC; c++) begin
      chk("rst_tx",    c, 16'(tx_o[c]),   16'd1);
      chk("rst_ready", c, 16'(rdy_o[c]),  16'd1);
      chk("rst_busy",  c, 16'(busy_o[c]), 16'd0);
      chk("rst_ctr",   c, ctr_o[c],       16'd0);
      chk("rst_stage", c, 16'(stg_o[c]),  16'd0);
    end
    rst = 1'b1;
    step(); step();
    for (int c = 0; c < NC; c++) chk("rst_drop_busy", c, 16'(busy_o[c]), 16'd0);

    // Single frame 0x55: start bit appears two edges after the write.
    clear_busy();
    tx_en = 1'b1; tx_data = 8'h55; step(); tx_en = 1'b0;
    step(); chk("lat_idle", 0, 16'(tx_o[0]), 16'd1);
    step(); chk("lat_start", 0, 16'(tx_o[0]), 16'd0);
    repeat (50) step();
    for (int c = 0; c < NC; c++) chk("len_55", c, 16'(busy_cnt[c]), 16'(EXP_LEN[c]));

    // 0x00: odd parity bit is 1, even parity bit is 0.
    tx_en = 1'b1; tx_data = 8'h00; step(); tx_en = 1'b0;
    k = edge_n;
    while (edge_n < k + 2 + 9 * B) step();
    chk("par_even", 1, 16'(tx_o[1]), 16'd0);
    chk("par_odd",  2, 16'(tx_o[2]), 16'd1);
    chk("stop_np",  0, 16'(tx_o[0]), 16'd1);
    repeat (20) step();

    // 0x7F: 8-bit config sends bit7=0, 7-bit config is already in stop bits.
    tx_en = 1'b1; tx_data = 8'h7F; step(); tx_en = 1'b0;
    k = edge_n;
    while (edge_n < k + 2 + 8 * B) step();
    chk("d7_bit8", 0, 16'(tx_o[0]), 16'd0);
    chk("d7_stop", 3, 16'(tx_o[3]), 16'd1);
    repeat (20) step();

    // Six writes on consecutive edges: one popped, four stored, sixth dropped.
    clear_busy();
    for (int i = 0; i < 6; i++) begin
      tx_en = 1'b1; tx_data = 8'($urandom);
      step();
      if (i == 4) for (int c = 0; c < NC; c++) chk("full_ready", c, 16'(rdy_o[c]), 16'd0);
    end
    tx_en = 1'b0;
    repeat (5 * 44 + 10) step();
    for (int c = 0; c < NC; c++) chk("b2b_len", c, 16'(busy_cnt[c]), 16'(5 * EXP_LEN[c]));

    // Randomized write traffic.
    repeat (1500) begin
      tx_en   = ($urandom_range(0, 7) == 0);
      tx_data = 8'($urandom);
      step();
    end
    tx_en = 1'b0;
    repeat (250) step();

    // Mid-frame reset during data bit 3 with two words queued.
    for (int i = 0; i < 3; i++) begin
      tx_en = 1'b1; tx_data = 8'($urandom);
      step();
      if (i == 0) k = edge_n;
    end
    tx_en = 1'b0;
    while (edge_n < k + 1 + 4 * B) step();
    chk("pre_rst_stage", 0, 16'(stg_o[0]), 16'd4);
    rst = 1'b0; step(); rst = 1'b1;
    for (int c = 0; c < NC; c++) begin
      chk("abort_tx",    c, 16'(tx_o[c]),   16'd1);
      chk("abort_ready", c, 16'(rdy_o[c]),  16'd1);
      chk("abort_busy",  c, 16'(busy_o[c]), 16'd0);
    end
    clear_busy();
    repeat (100) step();
    for (int c = 0; c < NC; c++) chk("abort_quiet", c, 16'(busy_cnt[c]), 16'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
